// File: rtl/global_trigger_ctrl_pkg.sv
// Shared constants for the global trigger scheduler and the Thresholder frame format.
package global_trigger_pkg;
    localparam int CNT_W = 16;

    localparam logic [15:0] START_WORD = 16'hDEAD;
    localparam logic [15:0] END_WORD   = 16'h7FFF;

    typedef logic [1:0] trig_state_t;
    localparam trig_state_t IDLE     = 2'd0;
    localparam trig_state_t HOLD     = 2'd1;
    localparam trig_state_t DEAD     = 2'd2;
    localparam trig_state_t WAIT_ACK = 2'd3;
endpackage

// File: rtl/global_trigger_ctrl_if.sv
// Trigger record handshake towards the downstream readout.
interface global_trigger_ctrl_if #(
    parameter int N_CH = 4,
    parameter int TS_W = 16
);
    localparam int IDX_W = $clog2(N_CH);

    logic             trig_valid;
    logic             trig_ready;
    logic [IDX_W-1:0] trig_ch;
    logic [TS_W-1:0]  trig_ts;
    logic [N_CH-1:0]  trig_mask;

    modport master (output trig_valid, trig_ch, trig_ts, trig_mask, input trig_ready);
    modport slave  (input trig_valid, trig_ch, trig_ts, trig_mask, output trig_ready);
endinterface

// File: rtl/global_trigger_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    int               j;
    logic [IDX_W-1:0] jj;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        jj      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_CH) j = j - N_CH;
            jj = IDX_W'(j);
            if (req[jj]) begin
                gnt     = N_CH'(1) << jj;
                gnt_idx = jj;
            end
        end
    end
endmodule

// File: rtl/global_trigger_ctrl.sv
// Global trigger scheduler: round-robin grant, flag hold window, dead time, record handshake.
// Optional TRIG_COUNTER_EN adds saturating accepted/lost counters.
module global_trigger_ctrl
    import global_trigger_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TS_W        = 16,
    parameter int HOLD_CYCLES = 128,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                 rx_std_clkout,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      ch_set_trigger,
    input  logic [N_CH*TS_W-1:0] ch_time_stamp,
    input  logic [N_CH-1:0]      ch_enable,
    output logic                 Global_trigger_flag,
    output logic                 busy,
    global_trigger_ctrl_if.master rec
`ifdef TRIG_COUNTER_EN
    ,
    output logic [CNT_W-1:0]     trig_count,
    output logic [CNT_W-1:0]     lost_count
`endif
);
    localparam int IDX_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);

    trig_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, ch_q, ch_d;
    logic [TS_W-1:0]  ts_q, ts_d, ts_sel;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic             valid_q, valid_d;
    logic [N_CH-1:0]  req, gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             accept;

    assign req    = ch_set_trigger & ch_enable;
    assign accept = valid_q & rec.trig_ready;

    rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        ts_sel = '0;
        for (int i = 0; i < N_CH; i++)
            if (gnt[i]) ts_sel = ts_sel | ch_time_stamp[i*TS_W +: TS_W];
    end

    // valid_d already reflects an acceptance this cycle, so the exit decisions use it directly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        ch_d     = ch_q;
        ts_d     = ts_q;
        mask_d   = mask_q;
        valid_d  = valid_q & ~rec.trig_ready;
        case (state_q)
            IDLE: if (|req) begin
                state_d  = HOLD;
                cnt_d    = HOLD_LOAD;
                ch_d     = gnt_idx;
                ts_d     = ts_sel;
                mask_d   = req;
                valid_d  = 1'b1;
                rr_ptr_d = (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
            HOLD: if (cnt_q == CNT_W'(1)) begin
                if (DEAD_CYCLES == 0) begin
                    state_d = valid_d ? WAIT_ACK : IDLE;
                end else begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            DEAD: if (cnt_q == CNT_W'(1)) state_d = valid_d ? WAIT_ACK : IDLE;
                  else cnt_d = cnt_q - 1'b1;
            WAIT_ACK: if (!valid_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            ch_q     <= '0;
            ts_q     <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            ch_q     <= ch_d;
            ts_q     <= ts_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
        end
    end

    assign Global_trigger_flag = (state_q == HOLD);
    assign busy                = (state_q != IDLE);
    assign rec.trig_valid      = valid_q;
    assign rec.trig_ch         = ch_q;
    assign rec.trig_ts         = ts_q;
    assign rec.trig_mask       = mask_q;

`ifdef TRIG_COUNTER_EN
    logic [CNT_W-1:0] trig_count_q, trig_count_d, lost_count_q, lost_count_d;

    always_comb begin
        trig_count_d = trig_count_q;
        lost_count_d = lost_count_q;
        if (accept && trig_count_q != '1) trig_count_d = trig_count_q + 1'b1;
        if ((|req) && state_q != IDLE && lost_count_q != '1) lost_count_d = lost_count_q + 1'b1;
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            trig_count_q <= '0;
            lost_count_q <= '0;
        end else begin
            trig_count_q <= trig_count_d;
            lost_count_q <= lost_count_d;
        end
    end

    assign trig_count = trig_count_q;
    assign lost_count = lost_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule
